// File: rtl/pipe_stage_chain.sv
// Multi-stage pipeline register chain with per-stage valid and payload, stall-bubble
// insertion, younger-stage flush, and saturating event counters.
module pipe_stage_chain #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in_valid,
  input  logic [DATA_WIDTH-1:0]        i_in_data,
  output logic                         o_in_ready,
  input  logic                         i_stall_en,
  input  logic [2:0]                   i_stall_stage,
  input  logic                         i_flush_en,
  input  logic [2:0]                   i_flush_stage,
  output logic [STAGES-1:0]            o_valid,
  output logic [STAGES*DATA_WIDTH-1:0] o_data,
  output logic                         o_out_valid,
  output logic [CNT_WIDTH-1:0]         o_bubble_cnt,
  output logic [CNT_WIDTH-1:0]         o_flush_cnt,
  output logic                         o_idx_err
);

  logic [31:0] stall_idx, flush_idx;
  logic        stall_ok, flush_ok, stall_eff, bubble_ins, idx_bad;

  logic [STAGES-1:0]     valid_q, valid_d, prev_valid;
  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [DATA_WIDTH-1:0] data_d [STAGES];
  logic [DATA_WIDTH-1:0] prev_data [STAGES];

  logic [CNT_WIDTH-1:0] bubble_cnt_q, flush_cnt_q;
  logic                 idx_err_q;

  assign stall_idx = {29'd0, i_stall_stage};
  assign flush_idx = {29'd0, i_flush_stage};

  // Requests with an index past the last stage are ignored entirely.
  assign stall_ok  = i_stall_en && (stall_idx < STAGES);
  assign flush_ok  = i_flush_en && (flush_idx < STAGES);
  assign idx_bad   = (i_stall_en && !stall_ok) || (i_flush_en && !flush_ok);
  assign stall_eff = stall_ok && !flush_ok;
  // Stalling the last stage freezes the whole chain, so nothing is injected.
  assign bubble_ins = stall_eff && ((stall_idx + 32'd1) < STAGES);

  assign o_in_ready = ~(flush_ok | stall_ok);

  always_comb begin
    prev_valid    = '0;
    prev_valid[0] = i_in_valid;
    prev_data[0]  = i_in_data;
    for (int unsigned k = 1; k < STAGES; k++) begin
      prev_valid[k] = valid_q[k-1];
      prev_data[k]  = data_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
      if (flush_ok) begin
        if (k <= flush_idx) begin
          valid_d[k] = 1'b0;
          data_d[k]  = '0;
        end else begin
          valid_d[k] = prev_valid[k];
          data_d[k]  = prev_data[k];
        end
      end else if (stall_eff) begin
        if (k <= stall_idx) begin
          valid_d[k] = valid_q[k];
          data_d[k]  = data_q[k];
        end else if (k == stall_idx + 32'd1) begin
          valid_d[k] = 1'b0;
          data_d[k]  = '0;
        end else begin
          valid_d[k] = prev_valid[k];
          data_d[k]  = prev_data[k];
        end
      end else begin
        valid_d[k] = prev_valid[k];
        data_d[k]  = prev_data[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      idx_err_q    <= 1'b0;
    end else begin
      if (bubble_ins && (bubble_cnt_q != {CNT_WIDTH{1'b1}})) begin
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
      if (flush_ok && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
      if (idx_bad) begin
        idx_err_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_out
    assign o_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
  end

  assign o_valid      = valid_q;
  assign o_out_valid  = valid_q[STAGES-1];
  assign o_bubble_cnt = bubble_cnt_q;
  assign o_flush_cnt  = flush_cnt_q;
  assign o_idx_err    = idx_err_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: stream, stall, flush, priority, index errors,
// counter saturation and asynchronous reset.
module tb_pipe_stage_chain;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 4;
  localparam int unsigned CW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic            stall_en = 1'b0;
  logic [2:0]      stall_stage = '0;
  logic            flush_en = 1'b0;
  logic [2:0]      flush_stage = '0;
  logic [NS-1:0]   valid;
  logic [NS*DW-1:0] data;
  logic            out_valid;
  logic [CW-1:0]   bubble_cnt, flush_cnt;
  logic            idx_err;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_chain #(
    .DATA_WIDTH(DW),
    .STAGES    (NS),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .i_stall_en   (stall_en),
    .i_stall_stage(stall_stage),
    .i_flush_en   (flush_en),
    .i_flush_stage(flush_stage),
    .o_valid      (valid),
    .o_data       (data),
    .o_out_valid  (out_valid),
    .o_bubble_cnt (bubble_cnt),
    .o_flush_cnt  (flush_cnt),
    .o_idx_err    (idx_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(valid), 64'h0);
    check_eq("rst_data", 64'(data), 64'h0);
    check_eq("rst_bcnt", 64'(bubble_cnt), 64'h0);
    check_eq("rst_fcnt", 64'(flush_cnt), 64'h0);
    check_eq("rst_idx_err", 64'(idx_err), 64'h0);
    rst = 1'b0;

    // Stream 1..6: stage 3 shows value j-3 after edge j
    for (int j = 1; j <= 9; j++) begin
      if (j <= 6) drive(1'b1, DW'(j));
      else drive(1'b0, '0);
      #1;
      check_eq("stream_ready", 64'(in_ready), 64'h1);
      step();
      check_eq("stream_out_valid", 64'(out_valid), (j >= 4) ? 64'h1 : 64'h0);
      if (j >= 4) check_eq("stream_out_data", 64'(data[31:24]), 64'(j - 3));
    end
    repeat (4) step();
    check_eq("drain_valid", 64'(valid), 64'h0);

    // Load-use stall at stage 0
    drive(1'b1, 8'h09); step();
    drive(1'b1, 8'h0A); step();
    drive(1'b1, 8'h0B);
    stall_en = 1'b1; stall_stage = 3'd0;
    #1;
    check_eq("stall_ready", 64'(in_ready), 64'h0);
    step();
    stall_en = 1'b0;
    check_eq("stall_valid", 64'(valid), 64'h5);
    check_eq("stall_data", 64'(data), 64'h0009000A);
    check_eq("stall_bcnt", 64'(bubble_cnt), 64'h1);

    // Fill 4,3,2,1 then flush at stage 2
    for (int j = 1; j <= 4; j++) begin
      drive(1'b1, DW'(j));
      step();
    end
    check_eq("fill_valid", 64'(valid), 64'hF);
    check_eq("fill_data", 64'(data), 64'h01020304);
    drive(1'b1, 8'h05);
    flush_en = 1'b1; flush_stage = 3'd2;
    #1;
    check_eq("flush_ready", 64'(in_ready), 64'h0);
    step();
    flush_en = 1'b0;
    check_eq("flush_valid", 64'(valid), 64'h8);
    check_eq("flush_data", 64'(data), 64'h02000000);
    check_eq("flush_fcnt", 64'(flush_cnt), 64'h1);

    // Simultaneous stall/flush at stage 1: flush wins
    drive(1'b1, 8'h11); step();
    drive(1'b1, 8'h12); step();
    drive(1'b1, 8'h13); step();
    check_eq("pre_both_valid", 64'(valid), 64'h7);
    drive(1'b1, 8'h14);
    stall_en = 1'b1; stall_stage = 3'd1;
    flush_en = 1'b1; flush_stage = 3'd1;
    step();
    stall_en = 1'b0; flush_en = 1'b0;
    check_eq("both_valid", 64'(valid), 64'hC);
    check_eq("both_data", 64'(data), 64'h11120000);
    check_eq("both_bcnt", 64'(bubble_cnt), 64'h1);
    check_eq("both_fcnt", 64'(flush_cnt), 64'h2);

    // Stall on last stage freezes everything, no bubble
    drive(1'b1, 8'h55);
    stall_en = 1'b1; stall_stage = 3'd3;
    #1;
    check_eq("hold_ready", 64'(in_ready), 64'h0);
    step();
    stall_en = 1'b0;
    check_eq("hold_valid", 64'(valid), 64'hC);
    check_eq("hold_data", 64'(data), 64'h11120000);
    check_eq("hold_bcnt", 64'(bubble_cnt), 64'h1);

    // Out-of-range flush index behaves as no request
    drive(1'b1, 8'h21);
    flush_en = 1'b1; flush_stage = 3'd5;
    #1;
    check_eq("oor_ready", 64'(in_ready), 64'h1);
    step();
    flush_en = 1'b0;
    check_eq("oor_valid", 64'(valid), 64'h9);
    check_eq("oor_data", 64'(data), 64'h12000021);
    check_eq("oor_idx_err", 64'(idx_err), 64'h1);
    check_eq("oor_fcnt", 64'(flush_cnt), 64'h2);
    drive(1'b0, '0);
    step();
    check_eq("idx_err_sticky", 64'(idx_err), 64'h1);

    // Counter saturation with 2-bit counters
    flush_en = 1'b1; flush_stage = 3'd0;
    repeat (3) step();
    flush_en = 1'b0;
    check_eq("fcnt_sat", 64'(flush_cnt), 64'h3);
    stall_en = 1'b1; stall_stage = 3'd0;
    repeat (3) step();
    stall_en = 1'b0;
    check_eq("bcnt_sat", 64'(bubble_cnt), 64'h3);

    // Asynchronous reset mid-stream
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 8'h30 + DW'(j));
      step();
    end
    check_eq("pre_rst_valid", 64'(valid), 64'h7);
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(valid), 64'h0);
    check_eq("arst_data", 64'(data), 64'h0);
    check_eq("arst_bcnt", 64'(bubble_cnt), 64'h0);
    check_eq("arst_fcnt", 64'(flush_cnt), 64'h0);
    check_eq("arst_idx_err", 64'(idx_err), 64'h0);
    drive(1'b1, 8'h77);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_hold_valid", 64'(valid), 64'h0);
    rst = 1'b0;
    step();
    check_eq("post_rst_valid", 64'(valid), 64'h1);
    check_eq("post_rst_data", 64'(data[7:0]), 64'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: payload width per stage, legal range 1..256.
REQ-002 The block SHALL have parameter STAGES, default 4: number of pipeline register stages, legal range 2..8; stage 0 is the youngest.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16: width of the event counters.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port i_clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port i_in_valid, input, 1 bit: the payload on i_in_data is offered to stage 0.
REQ-008 The block SHALL have port i_in_data, input, DATA_WIDTH bits: payload for stage 0.
REQ-009 The block SHALL have port o_in_ready, output, 1 bit: stage 0 captures input this cycle.
REQ-010 The block SHALL have port i_stall_en, input, 1 bit: a hold request is active.
REQ-011 The block SHALL have port i_stall_stage, input, 3 bits: the oldest stage to hold.
REQ-012 The block SHALL have port i_flush_en, input, 1 bit: a flush request is active.
REQ-013 The block SHALL have port i_flush_stage, input, 3 bits: the stage holding the flushing instruction.
REQ-014 The block SHALL have port o_valid, output, STAGES bits: per-stage valid flags.
REQ-015 The block SHALL have port o_data, output, STAGES*DATA_WIDTH bits: stage k payload at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-016 The block SHALL have port o_out_valid, output, 1 bit: equals o_valid[STAGES-1].
REQ-017 The block SHALL have port o_bubble_cnt, output, CNT_WIDTH bits: count of inserted stall bubbles.
REQ-018 The block SHALL have port o_flush_cnt, output, CNT_WIDTH bits: count of accepted flushes.
REQ-019 The block SHALL have port o_idx_err, output, 1 bit: sticky flag, set by an out-of-range stage index.

Function
REQ-020 The block SHALL, with no stall or flush active, advance every stage each cycle: stage 0 <= {i_in_valid, i_in_data}; stage k <= stage k-1.
REQ-021 The block SHALL drive o_in_ready = ~(i_flush_en_ok | i_stall_en_ok), combinationally; "_ok" means the request is enabled and its index is below STAGES.
REQ-022 The block SHALL, on a stall with index s, hold stages 0..s, load a bubble into stage s+1 when s+1 < STAGES, and advance stages above s+1 normally.
REQ-023 A bubble SHALL be valid=0 with payload all-zero.
REQ-024 The block SHALL, on a flush with index f, load bubbles into stages 0..f next cycle and advance stages f+1..STAGES-1 normally; stage f+1 receives the flusher.
REQ-025 The block SHALL give flush priority when stall and flush are both valid in the same cycle: the stall is ignored and no bubble is counted.
REQ-026 The block SHALL hold the entire chain on a stall with s = STAGES-1, with no bubble inserted and no count.
REQ-027 The block SHALL treat a stall or flush whose index is >= STAGES as absent and set o_idx_err, which stays set until reset.
REQ-028 The block SHALL increment o_bubble_cnt by 1 in each cycle that REQ-022 inserts a bubble; the counter saturates at all-ones.
REQ-029 The block SHALL increment o_flush_cnt by 1 in each accepted flush cycle; the counter saturates at all-ones.
REQ-030 The block SHALL have a latency of STAGES cycles from accepted input to o_out_valid when there are no stalls or flushes; throughput is 1 per cycle.
REQ-031 The block SHALL produce all outputs except o_in_ready directly from registers.

Reset
REQ-032 The block SHALL, while i_rst is high, asynchronously force all o_valid bits to 0, all o_data to 0, both counters to 0, and o_idx_err to 0.
REQ-033 The block SHALL, on i_rst assertion mid-operation, lose all in-flight entries; the first capture occurs on the first rising edge after i_rst falls.

Verification
REQ-034 Stream: STAGES=4, inputs 0x1..0x6 on consecutive cycles -> o_out_valid rises 4 cycles after first input; outputs appear in order 0x1..0x6 with no gaps.
REQ-035 Load-use stall: stall_en=1, stall_stage=0 for 1 cycle with 0xA in stage 0 -> stage 0 keeps 0xA, stage 1 becomes a bubble, o_in_ready=0, o_bubble_cnt=1.
REQ-036 Branch flush: stages 0..3 = 0x4,0x3,0x2,0x1; flush_stage=2 -> next cycle o_valid=4'b1000 with stage 3 = 0x2; o_flush_cnt=1.
REQ-037 Simultaneous stall_stage=1 and flush_stage=1 -> flush behaviour only; o_bubble_cnt unchanged; o_flush_cnt+1.
REQ-038 Out-of-range flush_stage=5 with STAGES=4 -> normal advance, o_idx_err=1 persisting until reset; CNT_WIDTH=2 with 5 flushes -> o_flush_cnt=3.
REQ-039 Assert i_rst mid-stream -> o_valid=0, counters=0 immediately, without waiting for a clock edge.
